// File: rtl/sample_stream_fsm_if.sv
// Flash read port bundle for sample_stream_fsm.
// master = the streaming FSM issuing reads, slave = the flash controller.
interface sample_stream_fsm_if #(
   parameter int ADDR_W = 23,
   parameter int WORD_W = 32
);
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic              flash_waitrequest;
   logic              flash_readdatavalid;
   logic [WORD_W-1:0] flash_readdata;

   modport master (
      output flash_read, flash_address,
      input  flash_waitrequest, flash_readdatavalid, flash_readdata
   );

   modport slave (
      input  flash_read, flash_address,
      output flash_waitrequest, flash_readdatavalid, flash_readdata
   );
endinterface

// File: rtl/sample_stream_fsm.sv
// Streams audio samples out of flash words: fetch a word, hand out its
// SAMPLE_W slices one per sample_req, then step to the next word.
// Build option: define SAMPLE_LOOP_EN to wrap the clip at either end
// (one-cycle end_reached pulse); otherwise playback stops at the clip end
// with end_reached sticky until restart or reset.
module sample_stream_fsm #(
   parameter int                ADDR_W     = 23,
   parameter int                WORD_W     = 32,
   parameter int                SAMPLE_W   = 8,
   parameter logic [ADDR_W-1:0] START_ADDR = 'h000000,
   parameter logic [ADDR_W-1:0] END_ADDR   = 'h07FFFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                play,
   input  logic                reverse,
   input  logic                restart,
   input  logic                sample_req,
   sample_stream_fsm_if.master flash,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                end_reached,
   output logic                underrun
);
   localparam int SPW    = WORD_W / SAMPLE_W;
   localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPW - 1);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_DATA, EMIT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic                dir_q, dir_d;
   logic                pend_q, pend_d;
   logic                read_q, read_d;
   logic [SAMPLE_W-1:0] out_q, out_d;
   logic                valid_q, valid_d;
   logic                end_q, end_d;
   logic                udr_q, udr_d;

   logic [SPW-1:0][SAMPLE_W-1:0] slots;
   logic [SLOT_W-1:0]            idx;
   logic [SAMPLE_W-1:0]          cur_sample;
   logic                         at_bound;
   logic                         stopped;
   logic                         do_restart;
   logic                         apply_restart;

   // slot_q counts samples taken from the word; dir picks which end we start at
   assign slots      = word_q;
   assign idx        = dir_q ? (LAST_SLOT - slot_q) : slot_q;
   assign cur_sample = slots[idx];
   assign at_bound   = dir_q ? (addr_q == START_ADDR) : (addr_q == END_ADDR);
   assign do_restart = pend_q | restart;
`ifdef SAMPLE_LOOP_EN
   assign stopped    = 1'b0;
`else
   assign stopped    = end_q;
`endif

   assign flash.flash_read    = read_q;
   assign flash.flash_address = addr_q;
   assign sample_out          = out_q;
   assign sample_valid        = valid_q;
   assign end_reached         = end_q;
   assign underrun            = udr_q;

   // next-state: sample path, fetch sequencing, word stepping, restart override
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      slot_d  = slot_q;
      dir_d   = dir_q;
      out_d   = out_q;
      udr_d   = udr_q;
      valid_d = sample_req;
      pend_d  = pend_q | restart;
`ifdef SAMPLE_LOOP_EN
      end_d   = 1'b0;
`else
      end_d   = end_q;
`endif
      apply_restart = 1'b0;

      // every request gets a strobe; outside EMIT the old sample is repeated
      if (sample_req) begin
         if (state_q != EMIT) udr_d = 1'b1;
         else if (!play)      out_d = '0;
         else                 out_d = cur_sample;
      end

      case (state_q)
         IDLE: begin
            if (do_restart)            apply_restart = 1'b1;
            else if (play && !stopped) state_d = FETCH;
         end
         FETCH: begin
            // read is in flight once the slave drops waitrequest; never abort it
            if (!flash.flash_waitrequest) state_d = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (flash.flash_readdatavalid) begin
               if (do_restart) apply_restart = 1'b1;
               else begin
                  word_d  = flash.flash_readdata;
                  dir_d   = reverse;
                  slot_d  = '0;
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (do_restart) apply_restart = 1'b1;
            else if (sample_req && play) begin
               if (slot_q == LAST_SLOT) begin
                  slot_d = '0;
                  if (at_bound) begin
`ifdef SAMPLE_LOOP_EN
                     addr_d  = dir_q ? END_ADDR : START_ADDR;
                     end_d   = 1'b1;
                     state_d = FETCH;
`else
                     end_d   = 1'b1;
                     state_d = IDLE;
`endif
                  end else begin
                     addr_d  = dir_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
                     state_d = FETCH;
                  end
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (apply_restart) begin
         addr_d  = reverse ? END_ADDR : START_ADDR;
         slot_d  = '0;
         end_d   = 1'b0;
         udr_d   = 1'b0;
         pend_d  = 1'b0;
         state_d = FETCH;
      end

      // flash_read is a registered decode of the next state
      read_d = (state_d == FETCH);
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= START_ADDR;
         word_q  <= '0;
         slot_q  <= '0;
         dir_q   <= 1'b0;
         pend_q  <= 1'b0;
         read_q  <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         udr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         slot_q  <= slot_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         read_q  <= read_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         udr_q   <= udr_d;
      end
   end
endmodule

// File: tb/tb_sample_stream_fsm.sv
// Bench for sample_stream_fsm: the bench plays the flash slave, drives
// playback controls, and checks every sample/address against a word-level
// model (clip contents, byte order by direction, address stepping).
module tb_sample_stream_fsm;
   localparam int ADDR_W = 23;
   localparam int WORD_W = 32;
   localparam int SPW    = 4;
   localparam logic [ADDR_W-1:0] START_A = 23'h000000;
   localparam logic [ADDR_W-1:0] END_A   = 23'h07FFFF;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       play = 1'b0, reverse = 1'b0, restart = 1'b0, sample_req = 1'b0;
   logic [7:0] sample_out;
   logic       sample_valid, end_reached, underrun;
   logic [7:0] last_out;
   int         total = 0;
   int         bad = 0;

   sample_stream_fsm_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) flash ();

   sample_stream_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .play         (play),
      .reverse      (reverse),
      .restart      (restart),
      .sample_req   (sample_req),
      .flash        (flash),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .end_reached  (end_reached),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   // clip contents: words 0 and 5 carry the reference pattern, others a hash
   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (a == 0 || a == 5) return 32'h44332211;
      return (32'(a) * 32'h9E3779B1) ^ 32'hA5C31E0F;
   endfunction

   // k-th sample played from word w: low byte first forward, high byte first reverse
   function automatic logic [7:0] exp_sample(input logic [31:0] w, input bit d, input int k);
      int b;
      b = d ? (SPW - 1 - k) : k;
      return 8'((w >> (8 * b)) & 32'hFF);
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // act as flash slave for one read at address a
   task automatic do_fetch(input logic [ADDR_W-1:0] a, input int nwait, input int lat,
                           input bit deliver, input bit req_in_wait);
      int n;
      int hi;
      n = 0;
      while (flash.flash_read !== 1'b1 && n < 20) begin step(); n++; end
      total++;
      if (flash.flash_read !== 1'b1) begin
         bad++;
         $display("FAIL fetch_start a=%h: flash_read=%b, want 1 within 20 cycles", a, flash.flash_read);
         return;
      end
      total++;
      if (flash.flash_address !== a) begin
         bad++;
         $display("FAIL fetch_addr: got %h want %h", flash.flash_address, a);
      end
      hi = 1;
      for (int i = 0; i < nwait; i++) begin
         flash.flash_waitrequest = 1'b1;
         step();
         if (flash.flash_read === 1'b1 && flash.flash_address === a) hi++;
      end
      flash.flash_waitrequest = 1'b0;
      step();
      total++;
      if (flash.flash_read !== 1'b0 || hi != nwait + 1) begin
         bad++;
         $display("FAIL fetch_hold a=%h: read stable %0d cycles then %b, want %0d then 0",
                  a, hi, flash.flash_read, nwait + 1);
      end
      if (req_in_wait) begin
         sample_req = 1'b1;
         step();
         sample_req = 1'b0;
         total++;
         if (sample_valid !== 1'b1 || sample_out !== last_out || underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_repeat: valid=%b out=%h udr=%b, want 1 %h 1",
                     sample_valid, sample_out, underrun, last_out);
         end
      end
      if (!deliver) return;
      repeat (lat) step();
      flash.flash_readdata      = mem_word(a);
      flash.flash_readdatavalid = 1'b1;
      step();
      flash.flash_readdatavalid = 1'b0;
      flash.flash_readdata      = $urandom;
   endtask

   // play one word; optional pause (play=0 request) before slot pause_at
   task automatic emit(input logic [31:0] w, input bit d, input int pause_at);
      logic [7:0] e;
      for (int k = 0; k < SPW; k++) begin
         repeat ($urandom_range(0, 2)) step();
         if (k == pause_at) begin
            play = 1'b0;
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
            play = 1'b1;
            total++;
            if (sample_valid !== 1'b1 || sample_out !== 8'h00) begin
               bad++;
               $display("FAIL pause: valid=%b out=%h, want 1 00", sample_valid, sample_out);
            end
            last_out = 8'h00;
            step();
         end
         e = exp_sample(w, d, k);
         sample_req = 1'b1;
         step();
         sample_req = 1'b0;
         total++;
         if (sample_valid !== 1'b1 || sample_out !== e) begin
            bad++;
            $display("FAIL emit w=%h k=%0d: valid=%b out=%h, want 1 %h", w, k, sample_valid, sample_out, e);
         end
         last_out = e;
         if (k != SPW - 1) begin
            step();
            total++;
            if (sample_valid !== 1'b0) begin
               bad++;
               $display("FAIL valid_len k=%0d: valid=%b, want 0", k, sample_valid);
            end
         end
      end
   endtask

   task automatic test_reset();
      flash.flash_waitrequest   = 1'b0;
      flash.flash_readdatavalid = 1'b0;
      flash.flash_readdata      = '0;
      rst_n = 1'b0;
      step(); step();
      total++;
      if (flash.flash_read !== 1'b0 || flash.flash_address !== START_A || sample_valid !== 1'b0 ||
          sample_out !== 8'h00 || end_reached !== 1'b0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL reset: rd=%b addr=%h v=%b out=%h end=%b udr=%b, want all 0",
                  flash.flash_read, flash.flash_address, sample_valid, sample_out, end_reached, underrun);
      end
      rst_n = 1'b1;
      step(); step();
      total++;
      if (flash.flash_read !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_play: flash_read=%b, want 0", flash.flash_read);
      end
   endtask

   // forward words 0..4, reverse change at word boundary, waitrequest stretch
   task automatic test_forward();
      logic [ADDR_W-1:0] a;
      play = 1'b1;
      reverse = 1'b0;
      a = START_A;
      for (int i = 0; i < 5; i++) begin
         do_fetch(a, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
         if (i == 4) reverse = 1'b1;
         emit(mem_word(a), 1'b0, (i == 2) ? 1 : -1);
         a = a + 1'b1;
      end
      do_fetch(23'd5, 3, 1, 1'b1, 1'b0);
      emit(mem_word(23'd5), 1'b1, -1);
      do_fetch(23'd4, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      reverse = 1'b0;
      emit(mem_word(23'd4), 1'b1, 2);
      do_fetch(23'd3, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      emit(mem_word(23'd3), 1'b0, -1);
   endtask

   // request outside EMIT, then a restart that waits for the issued read
   task automatic test_underrun();
      do_fetch(23'd4, 1, 3, 1'b1, 1'b1);
      emit(mem_word(23'd4), 1'b0, -1);
      total++;
      if (underrun !== 1'b1) begin
         bad++;
         $display("FAIL underrun_sticky: udr=%b, want 1", underrun);
      end
      restart = 1'b1;
      step();
      restart = 1'b0;
      flash.flash_readdata      = mem_word(23'd5);
      flash.flash_readdatavalid = 1'b1;
      step();
      flash.flash_readdatavalid = 1'b0;
      total++;
      if (flash.flash_read !== 1'b1 || flash.flash_address !== START_A || underrun !== 1'b0) begin
         bad++;
         $display("FAIL restart: rd=%b addr=%h udr=%b, want 1 %h 0",
                  flash.flash_read, flash.flash_address, underrun, START_A);
      end
      do_fetch(START_A, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      emit(mem_word(START_A), 1'b0, -1);
   endtask

   // reverse restart to END_ADDR, then play that word forward into the clip end
   task automatic test_end();
      int rd_seen;
      reverse = 1'b1;
      restart = 1'b1;
      step();
      restart = 1'b0;
      flash.flash_readdatavalid = 1'b1;
      flash.flash_readdata      = mem_word(23'd1);
      step();
      flash.flash_readdatavalid = 1'b0;
      reverse = 1'b0;
      do_fetch(END_A, 0, 1, 1'b1, 1'b0);
      emit(mem_word(END_A), 1'b0, -1);
`ifdef SAMPLE_LOOP_EN
      total++;
      if (end_reached !== 1'b1 || flash.flash_read !== 1'b1 || flash.flash_address !== START_A) begin
         bad++;
         $display("FAIL wrap: end=%b rd=%b addr=%h, want 1 1 %h",
                  end_reached, flash.flash_read, flash.flash_address, START_A);
      end
      flash.flash_waitrequest = 1'b1;
      step();
      total++;
      if (end_reached !== 1'b0) begin
         bad++;
         $display("FAIL wrap_pulse: end=%b, want 0", end_reached);
      end
      do_fetch(START_A, 1, 0, 1'b1, 1'b0);
      emit(mem_word(START_A), 1'b0, -1);
`else
      total++;
      if (end_reached !== 1'b1 || flash.flash_read !== 1'b0 || flash.flash_address !== END_A) begin
         bad++;
         $display("FAIL stop: end=%b rd=%b addr=%h, want 1 0 %h",
                  end_reached, flash.flash_read, flash.flash_address, END_A);
      end
      rd_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (flash.flash_read !== 1'b0) rd_seen++;
      end
      total++;
      if (rd_seen != 0 || end_reached !== 1'b1) begin
         bad++;
         $display("FAIL stop_hold: read cycles=%0d end=%b, want 0 1", rd_seen, end_reached);
      end
      restart = 1'b1;
      step();
      restart = 1'b0;
      total++;
      if (flash.flash_read !== 1'b1 || flash.flash_address !== START_A || end_reached !== 1'b0) begin
         bad++;
         $display("FAIL stop_restart: rd=%b addr=%h end=%b, want 1 %h 0",
                  flash.flash_read, flash.flash_address, end_reached, START_A);
      end
      do_fetch(START_A, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      emit(mem_word(START_A), 1'b0, -1);
`endif
   endtask

   // reset while a read awaits data; the late data must not be used
   task automatic test_reset_mid();
      int junk;
      do_fetch(23'd1, 0, 0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (flash.flash_read !== 1'b0 || flash.flash_address !== START_A || sample_valid !== 1'b0 ||
          sample_out !== 8'h00 || end_reached !== 1'b0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: rd=%b addr=%h v=%b out=%h end=%b udr=%b, want all 0",
                  flash.flash_read, flash.flash_address, sample_valid, sample_out, end_reached, underrun);
      end
      play = 1'b0;
      step();
      rst_n = 1'b1;
      flash.flash_readdata      = 32'hDEADBEEF;
      flash.flash_readdatavalid = 1'b1;
      step();
      flash.flash_readdatavalid = 1'b0;
      junk = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (flash.flash_read !== 1'b0 || sample_valid !== 1'b0) junk++;
      end
      total++;
      if (junk != 0) begin
         bad++;
         $display("FAIL late_rdv: %0d active cycles after reset, want 0", junk);
      end
      play = 1'b1;
      do_fetch(START_A, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0);
      emit(mem_word(START_A), 1'b0, -1);
   endtask

   initial begin
      last_out = 8'h00;
      test_reset();
      test_forward();
      test_underrun();
      test_end();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sample_stream_fsm.md
SAMPLE_STREAM_FSM -- requirements
Module: sample_stream_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, meaning flash word-address width.
REQ-002 SHALL have parameter WORD_W, default 32, meaning flash read-data width.
REQ-003 SHALL have parameter SAMPLE_W, default 8, meaning audio sample width; WORD_W SHALL be an integer multiple of SAMPLE_W, with SPW = WORD_W/SAMPLE_W slots per word.
REQ-004 SHALL have parameter START_ADDR, default 'h000000, meaning first word address of the clip.
REQ-005 SHALL have parameter END_ADDR, default 'h07FFFF, meaning last word address of the clip; END_ADDR SHALL be greater than or equal to START_ADDR.
REQ-006 SHALL have port clk, input, 1, meaning the single system clock.
REQ-007 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-008 SHALL have ports play / reverse / restart, input, 1 each, meaning level controls, synchronous to clk.
REQ-009 SHALL have port sample_req, input, 1, meaning a one-cycle strobe at the audio sample rate.
REQ-010 SHALL have port flash_read, output, 1, meaning the read request.
REQ-011 SHALL have port flash_address, output, ADDR_W, meaning the read word address.
REQ-012 SHALL have port flash_waitrequest, input, 1, meaning flash stall.
REQ-013 SHALL have ports flash_readdatavalid, input, 1, and flash_readdata, input, WORD_W, meaning returned data.
REQ-014 SHALL have ports sample_out, output, SAMPLE_W, and sample_valid, output, 1, meaning the audio sample and its strobe.
REQ-015 SHALL have ports end_reached, output, 1, and underrun, output, 1, meaning status flags.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT_DATA and EMIT.
REQ-017 IDLE SHALL go to FETCH when play=1; otherwise it SHALL stay in IDLE.
REQ-018 FETCH SHALL hold flash_read=1 and flash_address stable while flash_waitrequest=1.
REQ-019 FETCH SHALL go to WAIT_DATA on the first cycle with flash_read=1 and flash_waitrequest=0.
REQ-020 WAIT_DATA SHALL latch flash_readdata into a word register on flash_readdatavalid=1, latch reverse as word direction dir, and go to EMIT.
REQ-021 In EMIT, sample_req=1 with play=1 SHALL give sample_out = the current slot and sample_valid=1 on the next cycle.
  - Slot order with dir=0: slot 0 = bits [SAMPLE_W-1:0] first, ascending.
  - Slot order with dir=1: slot SPW-1 first, descending.
REQ-022 After the last slot of a word, the next cycle SHALL step the address and go to FETCH.
  - dir=0: address +1.
  - dir=1: address -1.
REQ-023 Wrap-around SHALL follow REQ-043.
REQ-024 While play=0 and sample_req=1, sample_out SHALL be 0 and sample_valid=1 on the next cycle, with slot and address unchanged.
REQ-025 play=0 SHALL NOT start a new FETCH; a read already in FETCH or WAIT_DATA SHALL complete.
REQ-026 sample_req=1 outside EMIT SHALL repeat the last sample_out with sample_valid=1 and set underrun, which is sticky until reset or restart.
REQ-027 restart=1 SHALL be recorded as pending.
REQ-028 A pending restart SHALL be applied in IDLE or EMIT, or on completion of WAIT_DATA; it SHALL never abort an issued read.
  - Address loads START_ADDR if reverse=0, END_ADDR if reverse=1.
  - Slot clears, end_reached and underrun clear, and the block goes to FETCH.
REQ-029 sample_valid SHALL be high for exactly one cycle per accepted sample_req.
REQ-030 flash_read SHALL be asserted only in FETCH.
REQ-031 A change of reverse SHALL take effect at the next word boundary only.

Reset
REQ-032 On rst_n=0, the block SHALL immediately enter IDLE, in any state including mid-read.
REQ-033 On rst_n=0, flash_address SHALL be START_ADDR.
REQ-034 On rst_n=0, the slot SHALL be 0 and the word register SHALL be 0.
REQ-035 On rst_n=0, flash_read, sample_valid, end_reached and underrun SHALL be 0, and sample_out SHALL be 0.
REQ-036 On rst_n=0, the pending restart SHALL be cleared.
REQ-037 A readdatavalid arriving after reset deasserts SHALL be ignored in IDLE.

Configuration
REQ-038 Macro SAMPLE_LOOP_EN SHALL select end-of-clip behaviour.
REQ-039 With SAMPLE_LOOP_EN defined, stepping past END_ADDR (dir=0) SHALL wrap to START_ADDR.
REQ-040 With SAMPLE_LOOP_EN defined, stepping below START_ADDR (dir=1) SHALL wrap to END_ADDR.
REQ-041 With SAMPLE_LOOP_EN defined, end_reached SHALL pulse high for one cycle at each wrap.
REQ-042 With SAMPLE_LOOP_EN undefined, at that boundary the address SHALL hold, end_reached SHALL set sticky and the block SHALL go to IDLE, ignoring play until restart or reset.
REQ-043 Wrap-around SHALL occur only with SAMPLE_LOOP_EN defined; without it the block SHALL stop as in REQ-042.

Verification
REQ-044 Defaults, forward play, word 0x44332211 at address 0, four sample_req -> sample_out 0x11, 0x22, 0x33, 0x44, then FETCH at address 1.
REQ-045 reverse=1 at address 5, word 0x44332211 -> sample_out 0x44, 0x33, 0x22, 0x11, then FETCH at address 4.
REQ-046 flash_waitrequest held 3 cycles -> flash_read high for 4 cycles with flash_address constant.
REQ-047 SAMPLE_LOOP_EN defined, forward at 0x07FFFF after slot 3 -> address 0x000000 with a one-cycle end_reached pulse; undefined -> address 0x07FFFF, end_reached=1, IDLE.
REQ-048 sample_req during WAIT_DATA -> previous sample repeated and underrun=1; then restart -> address 0, underrun=0.
REQ-049 rst_n low in WAIT_DATA -> IDLE with flash_address=0 and all outputs 0, and a late readdatavalid is ignored.
